// File: rtl/relu_pkg.sv
// rtl/relu_pkg.sv - shared sign-magnitude element format for the relu block
package relu_pkg;

    localparam int N        = 32;
    localparam int F        = 17;
    localparam int SIGN_BIT = N - 1;

endpackage

// File: rtl/relu_cell.sv
// rtl/relu_cell.sv - single-element ReLU: clamps negative sign-magnitude values to zero
module relu_cell
    import relu_pkg::*;
(
    input  logic [N-1:0] x,
    output logic [N-1:0] y,
    output logic         clamp
);

    // Sign bit alone decides; negative zero is clamped too.
    assign clamp = x[SIGN_BIT];
    assign y     = clamp ? '0 : x;

endmodule

// File: rtl/relu.sv
// rtl/relu.sv - R x C parallel ReLU with one-cycle registered result, clamp mask and clamp count
module relu
    import relu_pkg::*;
#(
    parameter int R = 6,
    parameter int C = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [N-1:0]                a [0:R-1][0:C-1],
    output logic                        out_valid,
    output logic [N-1:0]                c [0:R-1][0:C-1],
    output logic [R*C-1:0]              neg_mask,
    output logic [$clog2(R*C+1)-1:0]    neg_count
);

    localparam int E  = R * C;
    localparam int CW = $clog2(E + 1);

    logic [N-1:0]  res [0:R-1][0:C-1];
    logic [E-1:0]  clamp_flat;
    logic [CW-1:0] cnt_next;

    for (genvar r = 0; r < R; r++) begin : g_row
        for (genvar k = 0; k < C; k++) begin : g_col
            relu_cell u_cell (
                .x     (a[r][k]),
                .y     (res[r][k]),
                .clamp (clamp_flat[r*C+k])
            );
        end
    end

    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < E; i++) begin
            cnt_next = cnt_next + CW'(clamp_flat[i]);
        end
    end

    // Result, mask and count load together so they always describe the same matrix.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            neg_mask  <= '0;
            neg_count <= '0;
            for (int r = 0; r < R; r++) begin
                for (int k = 0; k < C; k++) begin
                    c[r][k] <= '0;
                end
            end
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                neg_mask  <= clamp_flat;
                neg_count <= cnt_next;
                for (int r = 0; r < R; r++) begin
                    for (int k = 0; k < C; k++) begin
                        c[r][k] <= res[r][k];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_relu.sv
// tb/tb_relu.sv - scoreboard bench for relu at 6x6 (directed) and 2x3 (random)
module tb_relu;
    import relu_pkg::*;

    localparam int R  = 6;
    localparam int C  = 6;
    localparam int E  = R * C;
    localparam int CW = $clog2(E + 1);
    localparam int R2 = 2;
    localparam int C2 = 3;
    localparam int E2 = R2 * C2;
    localparam int CW2 = $clog2(E2 + 1);
    localparam int W  = E * N;

    typedef logic [W-1:0] wide_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_valid2 = 1'b0;

    logic [N-1:0]   a  [0:R-1][0:C-1];
    logic [N-1:0]   c  [0:R-1][0:C-1];
    logic [N-1:0]   m  [0:R-1][0:C-1];
    logic           out_valid;
    logic [E-1:0]   neg_mask;
    logic [CW-1:0]  neg_count;

    logic [N-1:0]   a2 [0:R2-1][0:C2-1];
    logic [N-1:0]   c2 [0:R2-1][0:C2-1];
    logic [N-1:0]   m2 [0:R2-1][0:C2-1];
    logic           out_valid2;
    logic [E2-1:0]  neg_mask2;
    logic [CW2-1:0] neg_count2;

    int checks = 0;
    int fails  = 0;

    logic [E*N-1:0]  q_c  [$];
    logic [E-1:0]    q_m  [$];
    logic [CW-1:0]   q_n  [$];
    logic [E2*N-1:0] q2_c [$];
    logic [E2-1:0]   q2_m [$];
    logic [CW2-1:0]  q2_n [$];

    logic [E*N-1:0]  c_flat, last_c;
    logic [E2*N-1:0] c2_flat, last_c2;

    relu #(.R(R), .C(C)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .out_valid (out_valid),
        .c         (c),
        .neg_mask  (neg_mask),
        .neg_count (neg_count)
    );

    relu #(.R(R2), .C(C2)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid2),
        .a         (a2),
        .out_valid (out_valid2),
        .c         (c2),
        .neg_mask  (neg_mask2),
        .neg_count (neg_count2)
    );

    always #5 clk = ~clk;

    always_comb begin
        c_flat = '0;
        for (int r = 0; r < R; r++)
            for (int k = 0; k < C; k++)
                c_flat[(r*C+k)*N +: N] = c[r][k];
    end

    always_comb begin
        c2_flat = '0;
        for (int r = 0; r < R2; r++)
            for (int k = 0; k < C2; k++)
                c2_flat[(r*C2+k)*N +: N] = c2[r][k];
    end

    task automatic check(input string name, input wide_t act, input wide_t exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: pop on every out_valid, otherwise the held value must not move.
    always @(negedge clk) begin
        if (rst) begin
            last_c = '0;
            q_c.delete(); q_m.delete(); q_n.delete();
        end else if (out_valid) begin
            if (q_c.size() == 0) begin
                check("unexpected_out_valid", wide_t'(1'b1), wide_t'(1'b0));
            end else begin
                last_c = q_c.pop_front();
                check("c", wide_t'(c_flat), wide_t'(last_c));
                check("neg_mask", wide_t'(neg_mask), wide_t'(q_m.pop_front()));
                check("neg_count", wide_t'(neg_count), wide_t'(q_n.pop_front()));
            end
        end else begin
            check("c_held", wide_t'(c_flat), wide_t'(last_c));
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            last_c2 = '0;
            q2_c.delete(); q2_m.delete(); q2_n.delete();
        end else if (out_valid2) begin
            if (q2_c.size() == 0) begin
                check("unexpected_out_valid2", wide_t'(1'b1), wide_t'(1'b0));
            end else begin
                last_c2 = q2_c.pop_front();
                check("c2", wide_t'(c2_flat), wide_t'(last_c2));
                check("neg_mask2", wide_t'(neg_mask2), wide_t'(q2_m.pop_front()));
                check("neg_count2", wide_t'(neg_count2), wide_t'(q2_n.pop_front()));
            end
        end else begin
            check("c2_held", wide_t'(c2_flat), wide_t'(last_c2));
        end
    end

    task automatic send_exp(input logic [E*N-1:0] ec, input logic [E-1:0] em, input logic [CW-1:0] en);
        @(posedge clk); #1;
        a = m;
        in_valid = 1'b1;
        q_c.push_back(ec); q_m.push_back(em); q_n.push_back(en);
    endtask

    task automatic send_model();
        logic [E*N-1:0] ec;
        logic [E-1:0]   em;
        int             n;
        ec = '0; em = '0; n = 0;
        for (int r = 0; r < R; r++)
            for (int k = 0; k < C; k++)
                if (m[r][k][N-1]) begin
                    em[r*C+k] = 1'b1;
                    n++;
                end else begin
                    ec[(r*C+k)*N +: N] = m[r][k];
                end
        send_exp(ec, em, CW'(n));
    endtask

    task automatic send2_model();
        logic [E2*N-1:0] ec;
        logic [E2-1:0]   em;
        int              n;
        ec = '0; em = '0; n = 0;
        for (int r = 0; r < R2; r++)
            for (int k = 0; k < C2; k++)
                if (m2[r][k][N-1]) begin
                    em[r*C2+k] = 1'b1;
                    n++;
                end else begin
                    ec[(r*C2+k)*N +: N] = m2[r][k];
                end
        @(posedge clk); #1;
        a2 = m2;
        in_valid2 = 1'b1;
        q2_c.push_back(ec); q2_m.push_back(em); q2_n.push_back(CW2'(n));
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(posedge clk); #1;
            in_valid  = 1'b0;
            in_valid2 = 1'b0;
        end
    endtask

    task automatic fill(input logic [N-1:0] v);
        for (int r = 0; r < R; r++)
            for (int k = 0; k < C; k++)
                m[r][k] = v;
    endtask

    initial begin
        logic [E*N-1:0] ec;

        // Reset held with a live, partly negative input: outputs must stay cleared.
        fill(32'h8000_1234);
        m[2][2] = 32'h0000_5555;
        a = m;
        in_valid = 1'b1;
        for (int r = 0; r < R2; r++)
            for (int k = 0; k < C2; k++)
                a2[r][k] = 32'h8000_0001;
        in_valid2 = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_out_valid", wide_t'(out_valid), wide_t'(1'b0));
        check("rst_c", wide_t'(c_flat), wide_t'(1'b0));
        check("rst_neg_mask", wide_t'(neg_mask), wide_t'(1'b0));
        check("rst_neg_count", wide_t'(neg_count), wide_t'(1'b0));
        check("rst_out_valid2", wide_t'(out_valid2), wide_t'(1'b0));
        in_valid = 1'b0;
        in_valid2 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle(3);

        // All positive: passes through unchanged.
        fill(32'h0006_487E);
        send_exp({E{32'h0006_487E}}, '0, '0);

        // Two negatives at [1][4] and [3][4] -> bits 10 and 22.
        m[1][4] = 32'hF006_487E;
        m[3][4] = 32'hF006_487E;
        ec = {E{32'h0006_487E}};
        ec[10*N +: N] = '0;
        ec[22*N +: N] = '0;
        send_exp(ec, 36'h0_0040_0400, 6'd2);
        idle(2);

        // Negative zero and largest positive magnitude.
        fill(32'h0);
        m[0][0] = 32'h8000_0000;
        m[5][5] = 32'h7FFF_FFFF;
        ec = '0;
        ec[35*N +: N] = 32'h7FFF_FFFF;
        send_exp(ec, 36'h0_0000_0001, 6'd1);
        idle(1);

        // Three back-to-back matrices, then hold.
        fill(32'h0001_0000);
        m[0][1] = 32'hFFFF_FFFF;
        send_model();
        fill(32'h8000_0001);
        m[4][3] = 32'h0000_0001;
        send_model();
        fill(32'h1234_5678);
        m[5][0] = 32'h8765_4321;
        m[2][5] = 32'h8000_0000;
        send_model();
        idle(4);

        // Reset between edges while a matrix is in flight.
        fill(32'h0ABC_DEF0);
        send_model();
        fill(32'h8ABC_DEF0);
        send_model();
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", wide_t'(out_valid), wide_t'(1'b0));
        check("midrst_c", wide_t'(c_flat), wide_t'(1'b0));
        check("midrst_neg_mask", wide_t'(neg_mask), wide_t'(1'b0));
        check("midrst_neg_count", wide_t'(neg_count), wide_t'(1'b0));
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        idle(4);
        fill(32'h0000_0042);
        m[3][3] = 32'h8000_0042;
        send_model();
        idle(2);

        // Random sign-magnitude matrices on the 2x3 instance, every cycle.
        for (int t = 0; t < 16; t++) begin
            for (int r = 0; r < R2; r++)
                for (int k = 0; k < C2; k++) begin
                    logic [N-2:0] mag;
                    mag = ($urandom_range(0, 3) == 0) ? '0 : (N-1)'($urandom);
                    m2[r][k] = {1'($urandom_range(0, 1)), mag};
                end
            send2_model();
        end
        idle(4);

        check("drain_q", wide_t'(q_c.size()), wide_t'(0));
        check("drain_q2", wide_t'(q2_c.size()), wide_t'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/relu.md
RELU -- requirements
Module: relu

Interface
REQ-001 The module SHALL have parameter R, default 6, meaning matrix row count (>=1).
REQ-002 The module SHALL have parameter C, default 6, meaning matrix column count (>=1).
REQ-003 The module SHALL take element width `N` (32) and fraction width `F` (17) from the shared package, not as parameters.
REQ-004 Port clk SHALL be input, 1 bit: the single clock, rising-edge active.
REQ-005 Port rst SHALL be input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port in_valid SHALL be input, 1 bit: a holds a valid matrix this cycle.
REQ-007 Port a SHALL be input, unpacked [0:R-1][0:C-1] of N bits: input matrix, sign-magnitude, F fraction bits.
REQ-008 Port out_valid SHALL be output, 1 bit: c and neg_mask are valid.
REQ-009 Port c SHALL be output, unpacked [0:R-1][0:C-1] of N bits: ReLU result, same format as a.
REQ-010 Port neg_mask SHALL be output, R*C bits: bit r*C+k is set when element [r][k] was clamped.
REQ-011 Port neg_count SHALL be output, $clog2(R*C+1) bits: number of set bits in neg_mask.

Function
REQ-012 Element rule: if a[r][k][N-1]==1, c[r][k] SHALL be all zeros; otherwise c[r][k] SHALL equal a[r][k] bit-exact.
REQ-013 Negative zero (MSB=1, magnitude 0) SHALL produce 0 with its neg_mask bit set.
REQ-014 Latency SHALL be exactly 1 cycle: a sampled on a clk edge with in_valid=1 appears on c, neg_mask and neg_count after that edge, and out_valid=1 in that same cycle.
REQ-015 If in_valid=0 on an edge, out_valid SHALL be 0 after that edge, and c, neg_mask and neg_count SHALL hold their previous values.
REQ-016 Back-to-back valid inputs SHALL be accepted every cycle, giving full throughput with no stall and no ready signal.
REQ-017 neg_count SHALL be computed from the same sampled matrix as c, so the outputs are always mutually consistent.
REQ-018 All R*C elements SHALL be processed in parallel; there SHALL be no state machine.
REQ-019 Magnitude bits SHALL never be modified; there SHALL be no rounding or saturation.

Reset
REQ-020 While rst=1, asynchronously and independent of clk: out_valid=0, every c element=0, neg_mask=0, neg_count=0.
REQ-021 A rst assertion during streaming SHALL discard any in-flight matrix.
REQ-022 The first valid output after rst deasserts SHALL come from the first in_valid=1 edge after the deassertion.

Structure
REQ-023 The shared package SHALL define N=32, F=17, and the sign-bit index N-1.
REQ-024 A combinational sub-module relu_cell (one N-bit element in; N-bit result and clamp flag out) SHALL be instantiated R*C times in a generate loop.
REQ-025 The registers and the popcount SHALL live in relu.

Verification
REQ-026 All 36 elements = 0x0006487E with in_valid=1 -> next cycle all c = 0x0006487E, neg_mask=0, neg_count=0, out_valid=1.
REQ-027 Same matrix but a[1][4]=a[3][4]=0xF006487E -> those two c elements = 0x00000000, all others 0x0006487E, neg_mask bits 10 and 22 set, neg_count=2.
REQ-028 a[0][0]=0x80000000, a[5][5]=0x7FFFFFFF, rest 0 -> c[0][0]=0, c[5][5]=0x7FFFFFFF, neg_count=1.
REQ-029 Three consecutive valid matrices followed by in_valid=0 -> three consecutive out_valid pulses with the matching results, then out_valid=0 with c held.
REQ-030 Assert rst mid-stream, between clock edges -> outputs go to zero and out_valid=0 immediately; after release, no output until the next in_valid.
REQ-031 Random sign-magnitude matrices at R=2, C=3 -> c, neg_mask and neg_count match a scoreboard model every cycle.
